retire_stage: RTL and testbench
===============================

Name: retire_stage

Overview:
- Commit-side consumer of the ROB retire bundle, up to 3 entries per cycle, oldest in slot [2].
- Updates the architectural map table and returns freed physical registers to the free list.
- Reports the number of retired stores to the store queue and counts retired instructions.
- Raises branch-recovery and halt, and supplies a registered architectural map snapshot for rename restore after a flush.

Parameters:
PREG_W, 6, physical register index width
AREG_N, 32, number of architectural registers
CNT_W, 64, retired-instruction counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
retire_entry  in  ROB_ENTRY_PACKET[2:0]  retire bundle, [2] oldest; fields used: valid, dest_areg, Tnew, Told, is_store, halt, precise_state_need, target_pc
BPRecoverEN  out  1  combinational mispredict flush to ROB/RS/SQ/fetch
recover_pc  out  XLEN  redirect PC, valid while BPRecoverEN=1
archmap_restore_valid  out  1  registered pulse the cycle after BPRecoverEN
archmap_out  out  [AREG_N-1:0][PREG_W-1:0]  registered architectural map
fl_free_valid  out  [2:0]  free-list return valid per slot
fl_free_preg  out  [2:0][PREG_W-1:0]  freed physical register (Told)
sq_retire_num  out  2  stores retired this cycle
halt  out  1  registered; high once a halt entry retires
retired_cnt  out  CNT_W  total retired instructions

Behaviour:
- Clock is clock; reset is synchronous, active-high.
- Reset values:
  - archmap[i] = i.
  - State = RUN.
  - halt = 0, archmap_restore_valid = 0, retired_cnt = 0.
  - All combinational outputs are 0 when no slot is valid.
- FSM states: RUN, HALTED.
  - RUN -> HALTED: at the edge where a halt=1 entry is accepted.
  - HALTED exits only via reset.
  - In HALTED: inputs are ignored, all combinational outputs are 0, map and counter are frozen, halt = 1.
- Slot walk (RUN only), order [2], [1], [0]:
  - A slot is accepted if valid=1 and no older accepted slot in the same bundle is a terminator.
  - A terminator is an entry with halt=1 or precise_state_need=1.
  - Younger slots after a terminator are squashed: no effect, not counted.
- Accepted slot with dest_areg != 0:
  - archmap[dest_areg] <= Tnew.
  - fl_free_valid[slot] = 1, fl_free_preg[slot] = Told.
- dest_areg == 0: no map write and no free.
- Same-bundle writes to the same areg: the youngest accepted write wins in archmap.
- sq_retire_num = count of accepted entries with is_store=1 (0..3).
- retired_cnt += number of accepted slots, wrapping modulo 2^CNT_W.
- Mispredict: accepted entry with precise_state_need=1 and halt=0:
  - BPRecoverEN = 1 and recover_pc = target_pc in the same cycle.
  - The mispredicting entry itself retires fully (map write, free, count).
  - Next cycle: archmap_restore_valid = 1 for exactly one cycle, and archmap_out already includes this cycle's writes.
- halt and precise_state_need on the same entry: halt wins and BPRecoverEN = 0.
- Non-contiguous valid bits (e.g. 3'b101) are processed slot by slot. Invalid slots neither terminate nor squash.
- archmap_out always reflects the registered map.
- Reset while HALTED or during a recover cycle: reset dominates and archmap_restore_valid = 0.

Optional Feature:
RETIRE_PERF_CNT_EN
- Defined: adds outputs store_retired_cnt[CNT_W] and mispredict_cnt[CNT_W].
  - Both reset to 0 and wrap.
  - Incremented by sq_retire_num and by BPRecoverEN respectively.
  - Frozen in HALTED.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- After reset, archmap_out[i] = i, halt = 0, retired_cnt = 0. Bundle of 3 valid entries (areg 1/2/3, Tnew 40/41/42, Told 1/2/3) -> next cycle archmap[1..3] = 40/41/42, fl_free_preg = {3,2,1} same cycle, retired_cnt = 3.
- Slot [1] precise_state_need=1 with target_pc=0x1000, slot [0] valid -> BPRecoverEN = 1 and recover_pc = 0x1000 same cycle. Slot [0] has no map write or free, retired_cnt += 2. archmap_restore_valid = 1 next cycle only.
- Slots [2] and [1] both write areg 5 (Tnew 50, then 51) -> archmap[5] = 51; both Told values freed.
- Bundle with is_store = {1,0,1} all valid -> sq_retire_num = 2. Same bundle with slot [2] halt=1 -> sq_retire_num = 1, halt = 1 next cycle, and all later bundles are ignored.
- dest_areg = 0 entry -> fl_free_valid = 0 for that slot, archmap[0] stays 0, retired_cnt still increments.
- Reset asserted while HALTED -> next cycle halt = 0, state RUN, archmap identity, retired_cnt = 0.

Source files
------------

// File: rtl/retire_stage.sv
// retire_stage: ROB retire commit (arch map, free list, store count, recover/halt); `RETIRE_PERF_CNT_EN adds perf counters
package retire_pkg;
  localparam int XLEN = 32;
  localparam int RP_PREG_W = 6;
  localparam int RP_AREG_W = 5;
  typedef struct packed {
    logic                 valid;
    logic [RP_AREG_W-1:0] dest_areg;
    logic [RP_PREG_W-1:0] Tnew;
    logic [RP_PREG_W-1:0] Told;
    logic                 is_store;
    logic                 halt;
    logic                 precise_state_need;
    logic [XLEN-1:0]      target_pc;
  } ROB_ENTRY_PACKET;
endpackage

module retire_stage
  import retire_pkg::*;
#(
  parameter int PREG_W = RP_PREG_W,
  parameter int AREG_N = 32,
  parameter int CNT_W  = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  ROB_ENTRY_PACKET [2:0]          retire_entry,
  output logic                           BPRecoverEN,
  output logic [XLEN-1:0]                recover_pc,
  output logic                           archmap_restore_valid,
  output logic [AREG_N-1:0][PREG_W-1:0]  archmap_out,
  output logic [2:0]                     fl_free_valid,
  output logic [2:0][PREG_W-1:0]         fl_free_preg,
  output logic [1:0]                     sq_retire_num,
  output logic                           halt,
  output logic [CNT_W-1:0]               retired_cnt
`ifdef RETIRE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]               store_retired_cnt,
  output logic [CNT_W-1:0]               mispredict_cnt
`endif
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t r_state, w_state_nxt;
  logic [AREG_N-1:0][PREG_W-1:0] r_map, w_map_nxt;
  logic [2:0] w_acc;
  logic w_stop, w_halt_take;
  logic [1:0] w_ret_num;
  logic r_restore;
  logic [CNT_W-1:0] r_cnt;
  always_comb begin
    w_acc = '0;
    w_stop = 1'b0;
    w_halt_take = 1'b0;
    w_ret_num = '0;
    w_map_nxt = r_map;
    BPRecoverEN = 1'b0;
    recover_pc = '0;
    fl_free_valid = '0;
    fl_free_preg = '0;
    sq_retire_num = '0;
    // oldest first so the youngest same-areg write lands last
    for (int k = 2; k >= 0; k--) begin
      w_acc[k] = r_state == RUN && retire_entry[k].valid && !w_stop;
      if (w_acc[k]) begin
        w_stop = retire_entry[k].halt || retire_entry[k].precise_state_need;
        w_halt_take = w_halt_take || retire_entry[k].halt;
        if (retire_entry[k].precise_state_need && !retire_entry[k].halt) begin
          BPRecoverEN = 1'b1;
          recover_pc = retire_entry[k].target_pc;
        end
        sq_retire_num = sq_retire_num + {1'b0, retire_entry[k].is_store};
        w_ret_num = w_ret_num + 2'd1;
        if (retire_entry[k].dest_areg != '0) begin
          w_map_nxt[retire_entry[k].dest_areg] = retire_entry[k].Tnew;
          fl_free_valid[k] = 1'b1;
          fl_free_preg[k] = retire_entry[k].Told;
        end
      end
    end
    w_state_nxt = (r_state == RUN && w_halt_take) ? HALTED : r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_restore <= 1'b0;
      r_cnt <= '0;
      for (int a = 0; a < AREG_N; a++) r_map[a] <= PREG_W'(a);
    end else begin
      r_state <= w_state_nxt;
      r_restore <= BPRecoverEN;
      r_map <= w_map_nxt;
      r_cnt <= r_cnt + CNT_W'(w_ret_num);
    end
  end
`ifdef RETIRE_PERF_CNT_EN
  logic [CNT_W-1:0] r_st_cnt, r_mp_cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_st_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      r_st_cnt <= r_st_cnt + CNT_W'(sq_retire_num);
      r_mp_cnt <= r_mp_cnt + CNT_W'(BPRecoverEN);
    end
  end
  assign store_retired_cnt = r_st_cnt;
  assign mispredict_cnt = r_mp_cnt;
`endif
  assign archmap_out = r_map;
  assign archmap_restore_valid = r_restore;
  assign halt = r_state == HALTED;
  assign retired_cnt = r_cnt;
endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: directed scoreboard bench for retire_stage
module tb_retire_stage;
  import retire_pkg::*;
  logic clock = 1'b0;
  logic reset;
  ROB_ENTRY_PACKET [2:0] bundle;
  logic bp_en, restore_v, halt_o;
  logic [31:0] rpc;
  logic [31:0][5:0] map;
  logic [2:0] ffv;
  logic [2:0][5:0] fpreg;
  logic [1:0] sqn;
  logic [63:0] rcnt;
`ifdef RETIRE_PERF_CNT_EN
  logic [63:0] st_cnt, mp_cnt;
`endif
  int errors = 0;
  int checks = 0;
  string q_tag[$];
  logic [63:0] q_exp[$];
  always #5 clock = ~clock;
  retire_stage dut (
    .clock(clock), .reset(reset), .retire_entry(bundle),
    .BPRecoverEN(bp_en), .recover_pc(rpc), .archmap_restore_valid(restore_v),
    .archmap_out(map), .fl_free_valid(ffv), .fl_free_preg(fpreg),
    .sq_retire_num(sqn), .halt(halt_o), .retired_cnt(rcnt)
`ifdef RETIRE_PERF_CNT_EN
    , .store_retired_cnt(st_cnt), .mispredict_cnt(mp_cnt)
`endif
  );
  function automatic ROB_ENTRY_PACKET mk(logic v, logic [4:0] a, logic [5:0] tn, logic [5:0] to,
                                         logic st, logic h, logic p, logic [31:0] pc);
    ROB_ENTRY_PACKET e;
    e = '{v, a, tn, to, st, h, p, pc};
    return e;
  endfunction
  task automatic push(input string t, input logic [63:0] v);
    q_tag.push_back(t);
    q_exp.push_back(v);
  endtask
  task automatic pop(input logic [63:0] obs);
    string t;
    logic [63:0] e;
    checks++;
    if (q_exp.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %0h expected nothing", obs);
    end else begin
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: got %0h expected %0h", t, obs, e);
      end
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    bundle = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push("reset_map", 64'(i));
      pop(64'(map[i]));
    end
    push("reset_halt", 0); push("reset_cnt", 0); push("reset_restore", 0);
    push("idle_ffv", 0); push("idle_bp", 0); push("idle_rpc", 0); push("idle_sq", 0);
    #1;
    pop(64'(halt_o)); pop(rcnt); pop(64'(restore_v));
    pop(64'(ffv)); pop(64'(bp_en)); pop(64'(rpc)); pop(64'(sqn));
    // three plain writes
    bundle[2] = mk(1, 1, 40, 1, 0, 0, 0, 0);
    bundle[1] = mk(1, 2, 41, 2, 0, 0, 0, 0);
    bundle[0] = mk(1, 3, 42, 3, 0, 0, 0, 0);
    push("b3_ffv", 3'b111); push("b3_preg2", 1); push("b3_preg1", 2); push("b3_preg0", 3); push("b3_bp", 0);
    #1;
    pop(64'(ffv)); pop(64'(fpreg[2])); pop(64'(fpreg[1])); pop(64'(fpreg[0])); pop(64'(bp_en));
    push("b3_map1", 40); push("b3_map2", 41); push("b3_map3", 42); push("b3_cnt", 3);
    tick();
    pop(64'(map[1])); pop(64'(map[2])); pop(64'(map[3])); pop(rcnt);
    // mispredict in slot 1 squashes slot 0
    bundle[2] = mk(1, 4, 44, 4, 0, 0, 0, 0);
    bundle[1] = mk(1, 6, 46, 6, 0, 0, 1, 32'h1000);
    bundle[0] = mk(1, 7, 47, 7, 0, 0, 0, 0);
    push("mp_bp", 1); push("mp_rpc", 32'h1000); push("mp_ffv", 3'b110); push("mp_restore_early", 0);
    #1;
    pop(64'(bp_en)); pop(rpc); pop(64'(ffv)); pop(64'(restore_v));
    push("mp_restore", 1); push("mp_map4", 44); push("mp_map6", 46); push("mp_map7", 7); push("mp_cnt", 5);
    tick();
    pop(64'(restore_v)); pop(64'(map[4])); pop(64'(map[6])); pop(64'(map[7])); pop(rcnt);
    bundle = '0;
    push("mp_restore_off", 0);
    tick();
    pop(64'(restore_v));
    // same areg twice: younger wins, both freed
    bundle[2] = mk(1, 5, 50, 5, 0, 0, 0, 0);
    bundle[1] = mk(1, 5, 51, 50, 0, 0, 0, 0);
    bundle[0] = '0;
    push("waw_ffv", 3'b110); push("waw_preg2", 5); push("waw_preg1", 50);
    #1;
    pop(64'(ffv)); pop(64'(fpreg[2])); pop(64'(fpreg[1]));
    push("waw_map5", 51); push("waw_cnt", 7);
    tick();
    pop(64'(map[5])); pop(rcnt);
    // 3'b101 with areg 0 in slot 0; invalid slot 1 carries a stale terminator
    bundle[2] = mk(1, 8, 52, 8, 0, 0, 0, 0);
    bundle[1] = mk(0, 9, 9, 9, 0, 1, 1, 32'h2000);
    bundle[0] = mk(1, 0, 60, 0, 0, 0, 0, 0);
    push("a0_ffv", 3'b100); push("a0_bp", 0);
    #1;
    pop(64'(ffv)); pop(64'(bp_en));
    push("a0_map0", 0); push("a0_map8", 52); push("a0_cnt", 9); push("a0_halt", 0);
    tick();
    pop(64'(map[0])); pop(64'(map[8])); pop(rcnt); pop(64'(halt_o));
    // stores {1,0,1}
    bundle[2] = mk(1, 9, 53, 9, 1, 0, 0, 0);
    bundle[1] = mk(1, 10, 54, 10, 0, 0, 0, 0);
    bundle[0] = mk(1, 11, 55, 11, 1, 0, 0, 0);
    push("st_sq", 2);
    #1;
    pop(64'(sqn));
    push("st_cnt", 12); push("st_map11", 55);
    tick();
    pop(rcnt); pop(64'(map[11]));
    // halt+psn on oldest: halt wins, younger squashed
    bundle[2] = mk(1, 9, 31, 9, 1, 1, 1, 32'h3000);
    bundle[1] = mk(1, 10, 30, 10, 0, 0, 0, 0);
    bundle[0] = mk(1, 11, 29, 11, 1, 0, 0, 0);
    push("h_sq", 1); push("h_ffv", 3'b100); push("h_bp", 0); push("h_rpc", 0);
    #1;
    pop(64'(sqn)); pop(64'(ffv)); pop(64'(bp_en)); pop(rpc);
    push("h_halt", 1); push("h_cnt", 13); push("h_map9", 31); push("h_map10", 54); push("h_restore", 0);
    tick();
    pop(64'(halt_o)); pop(rcnt); pop(64'(map[9])); pop(64'(map[10])); pop(64'(restore_v));
    // halted: everything ignored
    bundle[2] = mk(1, 4, 63, 4, 1, 0, 0, 0);
    bundle[1] = mk(1, 6, 62, 6, 0, 0, 1, 32'h4000);
    bundle[0] = mk(1, 7, 61, 7, 0, 0, 0, 0);
    push("hd_bp", 0); push("hd_ffv", 0); push("hd_sq", 0); push("hd_rpc", 0);
    #1;
    pop(64'(bp_en)); pop(64'(ffv)); pop(64'(sqn)); pop(rpc);
    push("hd_cnt", 13); push("hd_map4", 44); push("hd_halt", 1); push("hd_restore", 0);
    tick();
    pop(rcnt); pop(64'(map[4])); pop(64'(halt_o)); pop(64'(restore_v));
    // reset out of HALTED
    reset = 1'b1;
    push("rs_halt", 0); push("rs_cnt", 0); push("rs_map4", 4); push("rs_map9", 9); push("rs_restore", 0);
    tick();
    pop(64'(halt_o)); pop(rcnt); pop(64'(map[4])); pop(64'(map[9])); pop(64'(restore_v));
    reset = 1'b0;
    bundle = '0;
    bundle[0] = mk(1, 2, 33, 2, 0, 0, 0, 0);
    push("run_ffv", 3'b001);
    #1;
    pop(64'(ffv));
    push("run_cnt", 1); push("run_map2", 33);
    tick();
    pop(rcnt); pop(64'(map[2]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
